// File: rtl/snes_bus_strobe.sv
// snes_bus_strobe: SNES bus front-end conditioning.
// Synchronizes the raw /RD, /WR, PHI2 and /RESET pins into the clk domain.
// It optionally de-glitches them, then emits one-clock event strobes.
// It also measures the CPU bus-cycle length in clk periods.
//
// Build option: define SNES_BUS_GLITCH_FILTER_EN to insert a run-length
// glitch filter (FILTER_LEN agreeing samples) after the synchronizers.
// Without it the synchronizer output is used directly.

module snes_bus_strobe #(
    parameter int SYNC_STAGES = 3,
    parameter int FILTER_LEN  = 3
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       SNES_READ,
    input  logic       SNES_WRITE,
    input  logic       SNES_CPU_CLK,
    input  logic       SNES_RESET,
    output logic       SNES_rd_strobe,
    output logic       SNES_wr_strobe,
    output logic       SNES_rd_start,
    output logic       SNES_cycle_start,
    output logic       SNES_reset_strobe,
    output logic       snes_in_reset,
    output logic [6:0] cycle_len,
    output logic       cycle_len_valid
);

    // Bit positions inside the packed pin vector
    localparam int B_RD  = 0;
    localparam int B_WR  = 1;
    localparam int B_CK  = 2;
    localparam int B_RST = 3;

    // Idle bus levels: /RD=1, /WR=1, PHI2=0, /RESET=0 (asserted, so the
    // first release after nrst always yields a reset strobe)
    localparam logic [3:0] IDLE_LVL = 4'b0011;

    localparam logic [6:0] CNT_MAX = 7'd127;

    typedef enum logic [1:0] {
        MEAS_IDLE  = 2'd0,
        MEAS_ARMED = 2'd1,
        MEAS_VALID = 2'd2
    } meas_t;

    // Parameters outside the legal range are rejected at elaboration
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || FILTER_LEN < 2 || FILTER_LEN > 7) begin : g_param_check
        $error("snes_bus_strobe: SYNC_STAGES must be 2..4 and FILTER_LEN 2..7");
    end

    logic [3:0] pins_s;
    logic [3:0] sync_r [SYNC_STAGES];
    logic [3:0] sync_last_s;
    logic [3:0] f_s;
    logic [3:0] f_d_r;

    logic       rd_rise_s;
    logic       rd_fall_s;
    logic       wr_rise_s;
    logic       ck_rise_s;
    logic       rst_rise_s;
    logic       rst_fall_s;
    logic       bus_live_s;

    logic [6:0] cnt_r;
    meas_t      meas_r;

    assign pins_s      = {SNES_RESET, SNES_CPU_CLK, SNES_WRITE, SNES_READ};
    assign sync_last_s = sync_r[SYNC_STAGES-1];

    // Multi-flop synchronizer chain for all four pins, seeded with idle levels
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= IDLE_LVL;
            end
        end else begin
            sync_r[0] <= pins_s;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

`ifdef SNES_BUS_GLITCH_FILTER_EN
    logic [3:0] filt_r;
    logic [2:0] run_r [4];

    // Run-length filter: a level flips only after FILTER_LEN consecutive
    // opposing samples; any agreeing sample restarts the run
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            filt_r <= IDLE_LVL;
            for (int i = 0; i < 4; i++) begin
                run_r[i] <= 3'd0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync_last_s[i] != filt_r[i]) begin
                    if (run_r[i] == 3'(FILTER_LEN - 1)) begin
                        filt_r[i] <= sync_last_s[i];
                        run_r[i]  <= 3'd0;
                    end else begin
                        run_r[i]  <= run_r[i] + 3'd1;
                    end
                end else begin
                    run_r[i] <= 3'd0;
                end
            end
        end
    end

    assign f_s = filt_r;
`else
    assign f_s = sync_last_s;
`endif

    // Edge decode between the current filtered level and its registered copy
    always_comb begin
        rd_rise_s  = f_s[B_RD]  & ~f_d_r[B_RD];
        rd_fall_s  = ~f_s[B_RD] &  f_d_r[B_RD];
        wr_rise_s  = f_s[B_WR]  & ~f_d_r[B_WR];
        ck_rise_s  = f_s[B_CK]  & ~f_d_r[B_CK];
        rst_rise_s = f_s[B_RST] & ~f_d_r[B_RST];
        rst_fall_s = ~f_s[B_RST] & f_d_r[B_RST];
        // Read/write strobes are only meaningful while /RESET is released;
        // this matches the snes_in_reset value shown in the strobe's clk
        bus_live_s = f_s[B_RST];
    end

    // Registered edge strobes and reset status
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            f_d_r             <= IDLE_LVL;
            SNES_rd_strobe    <= 1'b0;
            SNES_wr_strobe    <= 1'b0;
            SNES_rd_start     <= 1'b0;
            SNES_cycle_start  <= 1'b0;
            SNES_reset_strobe <= 1'b0;
            snes_in_reset     <= 1'b1;
        end else begin
            f_d_r             <= f_s;
            SNES_rd_strobe    <= rd_rise_s & bus_live_s;
            SNES_wr_strobe    <= wr_rise_s & bus_live_s;
            SNES_rd_start     <= rd_fall_s & bus_live_s;
            SNES_cycle_start  <= ck_rise_s;
            SNES_reset_strobe <= rst_rise_s;
            snes_in_reset     <= ~f_s[B_RST];
        end
    end

    // CPU cycle-length counter; the capture lands in the same clk as the
    // SNES_cycle_start pulse because both are driven from the same edge
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_r     <= 7'd0;
            cycle_len <= 7'd0;
        end else begin
            if (ck_rise_s) begin
                cycle_len <= cnt_r;
                cnt_r     <= 7'd1;
            end else if (cnt_r != CNT_MAX) begin
                cnt_r     <= cnt_r + 7'd1;
            end else begin
                cnt_r     <= cnt_r;
            end
        end
    end

    // Measurement qualifier: the first cycle start after reset only arms,
    // the second one proves a full cycle was counted
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            meas_r          <= MEAS_IDLE;
            cycle_len_valid <= 1'b0;
        end else if (rst_fall_s) begin
            meas_r          <= MEAS_IDLE;
            cycle_len_valid <= 1'b0;
        end else if (ck_rise_s) begin
            case (meas_r)
                MEAS_IDLE: begin
                    meas_r          <= MEAS_ARMED;
                    cycle_len_valid <= 1'b0;
                end
                MEAS_ARMED: begin
                    meas_r          <= MEAS_VALID;
                    cycle_len_valid <= 1'b1;
                end
                MEAS_VALID: begin
                    meas_r          <= MEAS_VALID;
                    cycle_len_valid <= 1'b1;
                end
                default: begin
                    meas_r          <= MEAS_IDLE;
                    cycle_len_valid <= 1'b0;
                end
            endcase
        end else begin
            meas_r          <= meas_r;
            cycle_len_valid <= cycle_len_valid;
        end
    end

endmodule

// File: tb/tb_snes_bus_strobe.sv
// tb_snes_bus_strobe: directed self-checking bench for snes_bus_strobe
// (default parameters). Pin-to-strobe latency is SYNC_STAGES+1 clk,
// plus FILTER_LEN when SNES_BUS_GLITCH_FILTER_EN is defined.

module tb_snes_bus_strobe;

`ifdef SNES_BUS_GLITCH_FILTER_EN
    localparam int LAT       = 7;
    localparam int GLITCH_WR = 0;
`else
    localparam int LAT       = 4;
    localparam int GLITCH_WR = 1;
`endif

    logic       clk = 1'b0;
    logic       nrst;
    logic       SNES_READ;
    logic       SNES_WRITE;
    logic       SNES_CPU_CLK;
    logic       SNES_RESET;
    logic       SNES_rd_strobe;
    logic       SNES_wr_strobe;
    logic       SNES_rd_start;
    logic       SNES_cycle_start;
    logic       SNES_reset_strobe;
    logic       snes_in_reset;
    logic [6:0] cycle_len;
    logic       cycle_len_valid;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Strobe monitors: pulse counts and the cycle stamp of the last pulse
    int n_rd_start = 0;
    int n_rd_str   = 0;
    int n_wr_str   = 0;
    int n_cyc      = 0;
    int n_rst      = 0;
    int t_rd_start = 0;
    int t_rd_str   = 0;
    int t_wr_str   = 0;
    int len_log [16];
    int val_log [16];

    snes_bus_strobe dut (
        .clk               (clk),
        .nrst              (nrst),
        .SNES_READ         (SNES_READ),
        .SNES_WRITE        (SNES_WRITE),
        .SNES_CPU_CLK      (SNES_CPU_CLK),
        .SNES_RESET        (SNES_RESET),
        .SNES_rd_strobe    (SNES_rd_strobe),
        .SNES_wr_strobe    (SNES_wr_strobe),
        .SNES_rd_start     (SNES_rd_start),
        .SNES_cycle_start  (SNES_cycle_start),
        .SNES_reset_strobe (SNES_reset_strobe),
        .snes_in_reset     (snes_in_reset),
        .cycle_len         (cycle_len),
        .cycle_len_valid   (cycle_len_valid)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Cycle stamp, advanced at every active edge
    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor sampled on the inactive edge
    always @(negedge clk) begin
        if (SNES_rd_start) begin
            n_rd_start <= n_rd_start + 1;
            t_rd_start <= cyc;
        end
        if (SNES_rd_strobe) begin
            n_rd_str <= n_rd_str + 1;
            t_rd_str <= cyc;
        end
        if (SNES_wr_strobe) begin
            n_wr_str <= n_wr_str + 1;
            t_wr_str <= cyc;
        end
        if (SNES_reset_strobe) begin
            n_rst <= n_rst + 1;
        end
        if (SNES_cycle_start) begin
            if (n_cyc < 16) begin
                len_log[n_cyc] <= int'(cycle_len);
                val_log[n_cyc] <= int'(cycle_len_valid);
            end
            n_cyc <= n_cyc + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Safety net so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int d;
        int b0;
        int b1;
        int bc;

        nrst         = 1'b0;
        SNES_READ    = 1'b1;
        SNES_WRITE   = 1'b1;
        SNES_CPU_CLK = 1'b0;
        SNES_RESET   = 1'b0;
        tick(3);

        // Reset state
        check("rst_in_reset", int'(snes_in_reset), 1);
        check("rst_cycle_len", int'(cycle_len), 0);
        check("rst_valid", int'(cycle_len_valid), 0);
        check("rst_strobes", int'({SNES_rd_strobe, SNES_wr_strobe, SNES_rd_start,
                                   SNES_cycle_start, SNES_reset_strobe}), 0);

        // /RESET held low 10 clk after nrst release, then released
        nrst = 1'b1;
        tick(10);
        check("hold_in_reset", int'(snes_in_reset), 1);
        check("hold_no_rst_strobe", n_rst, 0);
        SNES_RESET = 1'b1;
        tick(LAT - 1);
        check("rel_strobe_early", int'(SNES_reset_strobe), 0);
        check("rel_in_reset_early", int'(snes_in_reset), 1);
        tick(1);
        check("rel_strobe", int'(SNES_reset_strobe), 1);
        check("rel_in_reset", int'(snes_in_reset), 0);
        tick(1);
        check("rel_strobe_end", int'(SNES_reset_strobe), 0);
        tick(5);
        check("rel_count", n_rst, 1);

        // /RD low for 8 clk
        b0 = n_rd_start;
        b1 = n_rd_str;
        SNES_READ = 1'b0;
        d = cyc;
        tick(8);
        SNES_READ = 1'b1;
        tick(LAT + 4);
        check("rd_start_count", n_rd_start - b0, 1);
        check("rd_strobe_count", n_rd_str - b1, 1);
        check("rd_start_latency", t_rd_start - d, LAT);
        check("rd_gap", t_rd_str - t_rd_start, 8);

        // /RD and /WR released in the same clk
        SNES_READ  = 1'b0;
        SNES_WRITE = 1'b0;
        tick(6);
        b0 = n_rd_str;
        b1 = n_wr_str;
        SNES_READ  = 1'b1;
        SNES_WRITE = 1'b1;
        tick(LAT + 3);
        check("both_rd_count", n_rd_str - b0, 1);
        check("both_wr_count", n_wr_str - b1, 1);
        check("both_same_clk", t_rd_str - t_wr_str, 0);

        // /WR pulse while /RESET is low is suppressed
        SNES_RESET = 1'b0;
        tick(LAT + 3);
        check("wr_in_reset", int'(snes_in_reset), 1);
        b1 = n_wr_str;
        SNES_WRITE = 1'b0;
        tick(6);
        SNES_WRITE = 1'b1;
        tick(LAT + 3);
        check("wr_gated", n_wr_str - b1, 0);
        SNES_RESET = 1'b1;
        tick(LAT + 3);
        check("wr_released", int'(snes_in_reset), 0);
        SNES_WRITE = 1'b0;
        tick(6);
        SNES_WRITE = 1'b1;
        tick(LAT + 3);
        check("wr_after_release", n_wr_str - b1, 1);

        // 2-clk glitch on /WR
        b1 = n_wr_str;
        SNES_WRITE = 1'b0;
        tick(2);
        SNES_WRITE = 1'b1;
        tick(LAT + 4);
        check("wr_glitch", n_wr_str - b1, GLITCH_WR);

        // CPU clock periods 24, 24, 32, 48, then 200
        bc = n_cyc;
        SNES_CPU_CLK = 1'b1; tick(12); SNES_CPU_CLK = 1'b0; tick(12);
        SNES_CPU_CLK = 1'b1; tick(12); SNES_CPU_CLK = 1'b0; tick(12);
        SNES_CPU_CLK = 1'b1; tick(16); SNES_CPU_CLK = 1'b0; tick(16);
        SNES_CPU_CLK = 1'b1; tick(24); SNES_CPU_CLK = 1'b0; tick(24);
        SNES_CPU_CLK = 1'b1; tick(100); SNES_CPU_CLK = 1'b0; tick(100);
        SNES_CPU_CLK = 1'b1; tick(10); SNES_CPU_CLK = 1'b0;
        tick(LAT + 2);
        check("cyc_count", n_cyc - bc, 6);
        check("cyc0_valid", val_log[bc], 0);
        check("cyc1_valid", val_log[bc + 1], 1);
        check("cyc1_len", len_log[bc + 1], 24);
        check("cyc2_len", len_log[bc + 2], 24);
        check("cyc3_len", len_log[bc + 3], 32);
        check("cyc4_len", len_log[bc + 4], 48);
        check("cyc5_len_sat", len_log[bc + 5], 127);
        check("cyc_valid_held", int'(cycle_len_valid), 1);

        // Filtered /RESET fall clears valid, keeps the last length
        SNES_RESET = 1'b0;
        tick(LAT + 3);
        check("rstfall_valid", int'(cycle_len_valid), 0);
        check("rstfall_len", int'(cycle_len), 127);
        check("rstfall_in_reset", int'(snes_in_reset), 1);

        // nrst asserted in the middle of a /RD-low pulse
        SNES_RESET = 1'b1;
        tick(LAT + 3);
        SNES_READ = 1'b0;
        tick(LAT + 3);
        b0 = n_rd_start;
        b1 = n_rd_str;
        nrst       = 1'b0;
        SNES_RESET = 1'b0;
        tick(2);
        check("nrst_len", int'(cycle_len), 0);
        check("nrst_valid", int'(cycle_len_valid), 0);
        check("nrst_in_reset", int'(snes_in_reset), 1);
        nrst = 1'b1;
        tick(10);
        check("nrst_no_rd_start", n_rd_start - b0, 0);
        SNES_RESET = 1'b1;
        tick(LAT + 3);
        check("nrst_still_no_start", n_rd_start - b0, 0);
        check("nrst_no_early_strobe", n_rd_str - b1, 0);
        SNES_READ = 1'b1;
        d = cyc;
        tick(LAT + 3);
        check("nrst_rd_strobe", n_rd_str - b1, 1);
        check("nrst_rd_latency", t_rd_str - d, LAT);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
